// File: rtl/receiver.sv
// Oversampling 8N1 UART receiver: synchronizes RxD, finds the start-bit centre,
// then samples each data bit and the stop bit once per bit period.
module receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick_16x,
  input  logic       RxD,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       RDA,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic [CNT_W-1:0]       tick_cnt;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_reg;

  // Resetting the synchronizer to 1 keeps reset release from looking like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RxD};
    end
  end

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= 8'h00;
      RDA         <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // A bus read clears the flags; a stop sample in the same cycle overrides below.
      if (rx_read) begin
        RDA         <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
      end

      if (baud_tick_16x) begin
        unique case (state)
          IDLE: begin
            if (!line) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end

          START: begin
            if (tick_cnt == MID_CNT) begin
              if (!line) begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end

          DATA: begin
            if (tick_cnt == LAST_CNT) begin
              shift_reg <= {line, shift_reg[7:1]};
              tick_cnt  <= '0;
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end

          STOP: begin
            if (tick_cnt == LAST_CNT) begin
              tick_cnt <= '0;
              state    <= IDLE;
              if (line) begin
                rx_data <= shift_reg;
                RDA     <= 1'b1;
                if (RDA && !rx_read) begin
                  overrun_err <= 1'b1;
                end
              end else begin
                framing_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Directed self-checking bench for receiver: tick every 4 clk, frames driven
// bit by bit on tick boundaries, outputs checked on the falling clock edge.
module tb_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       RxD = 1'b1;
  logic       rx_read = 1'b0;
  logic       baud_tick_16x;
  logic [7:0] rx_data;
  logic       RDA;
  logic       framing_err;
  logic       overrun_err;
  logic [1:0] div = 2'd0;

  int total = 0;
  int bad   = 0;

  receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .baud_tick_16x(baud_tick_16x),
    .RxD          (RxD),
    .rx_read      (rx_read),
    .rx_data      (rx_data),
    .RDA          (RDA),
    .framing_err  (framing_err),
    .overrun_err  (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) div <= div + 2'd1;
  assign baud_tick_16x = (div == 2'd3);

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic waitTick();
    do @(negedge clk); while (baud_tick_16x !== 1'b1);
  endtask

  // Drives one frame, one bit per 16 ticks. The line change at tick 0 is seen
  // from tick 1, so the stop bit is sampled on tick 153. read_at pulses rx_read
  // on that tick's cycle; abort_at asserts reset there and leaves the line idle.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int read_at, input int abort_at);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int t = 0; t <= 170; t++) begin
      waitTick();
      if (t == abort_at) begin
        reset_n = 1'b0;
        RxD     = 1'b1;
        return;
      end
      if ((t % 16 == 0) && (t < 160)) RxD = frame[t / 16];
      if (t == 160) RxD = 1'b1;
      if (t == read_at) begin
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
      end
    end
  endtask

  task automatic pulseRead();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkFlag("reset RDA", RDA, 1'b0);
    checkFlag("reset framing_err", framing_err, 1'b0);
    checkFlag("reset overrun_err", overrun_err, 1'b0);
    reset_n = 1'b1;
    repeat (8) waitTick();

    // Good frame 0xA5
    applyStimulus(8'hA5, 1'b1, -1, -1);
    checkOutput("A5 rx_data", rx_data, 8'hA5);
    checkFlag("A5 RDA", RDA, 1'b1);
    checkFlag("A5 framing_err", framing_err, 1'b0);
    checkFlag("A5 overrun_err", overrun_err, 1'b0);
    pulseRead();
    checkFlag("A5 read clears RDA", RDA, 1'b0);
    checkOutput("A5 read keeps rx_data", rx_data, 8'hA5);

    // Five-tick glitch, then 0x3C
    waitTick();
    RxD = 1'b0;
    repeat (5) waitTick();
    RxD = 1'b1;
    repeat (20) waitTick();
    checkFlag("glitch RDA", RDA, 1'b0);
    checkFlag("glitch framing_err", framing_err, 1'b0);
    checkFlag("glitch overrun_err", overrun_err, 1'b0);
    applyStimulus(8'h3C, 1'b1, -1, -1);
    checkOutput("3C rx_data", rx_data, 8'h3C);
    checkFlag("3C RDA", RDA, 1'b1);
    pulseRead();

    // 0x55 with a low stop bit
    applyStimulus(8'h55, 1'b0, -1, -1);
    checkFlag("55 framing_err", framing_err, 1'b1);
    checkFlag("55 RDA", RDA, 1'b0);
    checkOutput("55 rx_data kept", rx_data, 8'h3C);
    pulseRead();
    checkFlag("55 read clears framing_err", framing_err, 1'b0);
    checkFlag("55 read leaves RDA low", RDA, 1'b0);
    checkOutput("55 read keeps rx_data", rx_data, 8'h3C);

    // Overrun: 0x11 then 0x22 unread
    applyStimulus(8'h11, 1'b1, -1, -1);
    checkOutput("11 rx_data", rx_data, 8'h11);
    checkFlag("11 overrun_err", overrun_err, 1'b0);
    applyStimulus(8'h22, 1'b1, -1, -1);
    checkOutput("overrun rx_data", rx_data, 8'h22);
    checkFlag("overrun RDA", RDA, 1'b1);
    checkFlag("overrun overrun_err", overrun_err, 1'b1);
    checkFlag("overrun framing_err", framing_err, 1'b0);
    pulseRead();
    checkFlag("overrun read clears RDA", RDA, 1'b0);
    checkFlag("overrun read clears overrun_err", overrun_err, 1'b0);

    // Read coinciding with the stop sample of the second frame
    applyStimulus(8'h11, 1'b1, -1, -1);
    checkFlag("race first RDA", RDA, 1'b1);
    applyStimulus(8'h22, 1'b1, 153, -1);
    checkOutput("race rx_data", rx_data, 8'h22);
    checkFlag("race RDA", RDA, 1'b1);
    checkFlag("race overrun_err", overrun_err, 1'b0);
    checkFlag("race framing_err", framing_err, 1'b0);

    // Reset during data bit 4
    applyStimulus(8'h5A, 1'b1, -1, 88);
    #1;
    checkOutput("midreset rx_data", rx_data, 8'h00);
    checkFlag("midreset RDA", RDA, 1'b0);
    checkFlag("midreset framing_err", framing_err, 1'b0);
    checkFlag("midreset overrun_err", overrun_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) waitTick();
    checkFlag("post-reset idle RDA", RDA, 1'b0);
    checkFlag("post-reset idle framing_err", framing_err, 1'b0);
    applyStimulus(8'hF0, 1'b1, -1, -1);
    checkOutput("F0 rx_data", rx_data, 8'hF0);
    checkFlag("F0 RDA", RDA, 1'b1);
    checkFlag("F0 framing_err", framing_err, 1'b0);
    checkFlag("F0 overrun_err", overrun_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
